// File: rtl/aes_cbc_request_tx_pkg.sv
// aes_cbc_request_tx_pkg: shared AES sizes for the request framer slice
package aes_cbc_request_tx_pkg;
  localparam int AES_BLOCK_SIZE = 128;
  localparam int AES_256_KEY_LENGTH = 256;
endpackage

// File: rtl/aes_cbc_request_tx_if.sv
// aes_cbc_request_tx_if: AXI-Stream bundle carrying framed requests to the cipher core
interface aes_cbc_request_tx_if #(parameter int AXIS_WIDTH = 64);
  logic [AXIS_WIDTH-1:0] tdata;
  logic [AXIS_WIDTH/8-1:0] tkeep;
  logic tuser;
  logic tlast;
  logic tvalid;
  logic tready;
  modport master(output tdata, tkeep, tuser, tlast, tvalid, input tready);
  modport slave(input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/aes_cbc_request_tx_serializer.sv
// aes_cbc_request_tx_serializer: slices a 128-bit word into AXIS_WIDTH beats, low beat first
module aes_cbc_request_tx_serializer
  import aes_cbc_request_tx_pkg::*;
#(
  parameter int AXIS_WIDTH = 64
) (
  input  logic Clk,
  input  logic Rst,
  input  logic [AES_BLOCK_SIZE-1:0] word,
  input  logic adv,
  input  logic clr,
  output logic [AXIS_WIDTH-1:0] beat,
  output logic last
);
  localparam int BEATS = AES_BLOCK_SIZE / AXIS_WIDTH;
  localparam int CW = $clog2(BEATS);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    last = cnt_q == CW'(BEATS - 1);
    cnt_d = clr ? '0 : adv ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    beat = word[int'(cnt_q)*AXIS_WIDTH +: AXIS_WIDTH];
  end
  always_ff @(posedge Clk) cnt_q <= Rst ? '0 : cnt_d;
endmodule

// File: rtl/aes_cbc_request_tx.sv
// aes_cbc_request_tx: frames key halves, IV and text blocks onto the AES-CBC core's AXIS input
module aes_cbc_request_tx
  import aes_cbc_request_tx_pkg::*;
#(
  parameter int AXIS_WIDTH = 64,
  parameter int LEN_WIDTH = 16
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Cmd_valid,
  output logic Cmd_ready,
  input  logic [AES_256_KEY_LENGTH-1:0] Cmd_key,
  input  logic [AES_BLOCK_SIZE-1:0] Cmd_iv,
  input  logic Cmd_enc,
  input  logic [LEN_WIDTH-1:0] Cmd_nblocks,
  input  logic Blk_valid,
  output logic Blk_ready,
  input  logic [AES_BLOCK_SIZE-1:0] Blk_data,
  aes_cbc_request_tx_if.master M_axis,
  output logic Busy,
  output logic Err_zero
);
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_KEY_0 = 5'b00010,
    ST_KEY_1 = 5'b00100,
    ST_IV    = 5'b01000,
    ST_TEXT  = 5'b10000
  } state_t;
  state_t st_q, st_d;
  logic [AES_256_KEY_LENGTH-1:0] key_q, key_d;
  logic [AES_BLOCK_SIZE-1:0] iv_q, iv_d, buf_q, buf_d, word;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic enc_q, enc_d, full_q, full_d, err_q, err_d;
  logic [AXIS_WIDTH-1:0] beat;
  logic last, hdr, text, tv, hs, cmd_hs, blk_hs, final_blk;
  assign hdr = st_q inside {ST_KEY_0, ST_KEY_1, ST_IV};
  assign text = st_q == ST_TEXT;
  assign tv = hdr | (text & full_q);
  assign hs = tv & M_axis.tready;
  assign final_blk = rem_q == LEN_WIDTH'(1);
  assign cmd_hs = Cmd_valid & (st_q == ST_IDLE);
  assign blk_hs = Blk_valid & text & ~full_q;
  assign word = st_q == ST_KEY_0 ? key_q[127:0] : st_q == ST_KEY_1 ? key_q[255:128] : st_q == ST_IV ? iv_q : buf_q;
  aes_cbc_request_tx_serializer #(.AXIS_WIDTH(AXIS_WIDTH)) u_ser (
    .Clk(Clk), .Rst(Rst), .word(word), .adv(hs), .clr(st_d != st_q), .beat(beat), .last(last)
  );
  always_comb begin
    st_d = st_q;
    key_d = key_q;
    iv_d = iv_q;
    enc_d = enc_q;
    rem_d = rem_q;
    buf_d = buf_q;
    full_d = full_q;
    err_d = cmd_hs & (Cmd_nblocks == '0);
    if (cmd_hs) begin
      key_d = Cmd_key;
      iv_d = Cmd_iv;
      enc_d = Cmd_enc;
      rem_d = Cmd_nblocks;
      st_d = Cmd_nblocks == '0 ? ST_IDLE : ST_KEY_0;
    end
    if (hdr & hs & last) st_d = st_q == ST_KEY_0 ? ST_KEY_1 : st_q == ST_KEY_1 ? ST_IV : ST_TEXT;
    if (blk_hs) begin
      buf_d = Blk_data;
      full_d = 1'b1;
    end
    // The last beat of a block frees the holding register and retires one block
    if (text & hs & last) begin
      full_d = 1'b0;
      rem_d = rem_q - LEN_WIDTH'(rem_q != '0);
      st_d = final_blk ? ST_IDLE : st_q;
    end
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      st_q <= ST_IDLE;
      key_q <= '0;
      iv_q <= '0;
      enc_q <= 1'b0;
      rem_q <= '0;
      buf_q <= '0;
      full_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      key_q <= key_d;
      iv_q <= iv_d;
      enc_q <= enc_d;
      rem_q <= rem_d;
      buf_q <= buf_d;
      full_q <= full_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    Cmd_ready = st_q == ST_IDLE;
    Blk_ready = text & ~full_q;
    Busy = st_q != ST_IDLE;
    Err_zero = err_q;
    M_axis.tvalid = tv;
    M_axis.tdata = tv ? beat : '0;
    M_axis.tkeep = {(AXIS_WIDTH/8){tv}};
    M_axis.tuser = tv & enc_q;
    M_axis.tlast = text & full_q & last & final_blk;
  end
endmodule

// File: tb/tb_aes_cbc_request_tx.sv
// tb_aes_cbc_request_tx: random and directed frames checked by a beat scoreboard
module tb_aes_cbc_request_tx;
  localparam int W = 64;
  localparam int B = 128 / W;
  localparam int LW = 16;
  localparam logic [W/8-1:0] KEEP = {(W/8){1'b1}};
  typedef struct packed {logic [W-1:0] d; logic u; logic l;} beat_t;
  logic Clk = 0, Rst = 1;
  logic Cmd_valid = 0, Cmd_ready, Cmd_enc = 0, Blk_valid = 0, Blk_ready, Busy, Err_zero;
  logic [255:0] Cmd_key = '0;
  logic [127:0] Cmd_iv = '0, Blk_data = '0;
  logic [LW-1:0] Cmd_nblocks = '0;
  aes_cbc_request_tx_if #(.AXIS_WIDTH(W)) m ();
  aes_cbc_request_tx #(.AXIS_WIDTH(W), .LEN_WIDTH(LW)) dut (
    .Clk(Clk), .Rst(Rst), .Cmd_valid(Cmd_valid), .Cmd_ready(Cmd_ready), .Cmd_key(Cmd_key),
    .Cmd_iv(Cmd_iv), .Cmd_enc(Cmd_enc), .Cmd_nblocks(Cmd_nblocks), .Blk_valid(Blk_valid),
    .Blk_ready(Blk_ready), .Blk_data(Blk_data), .M_axis(m), .Busy(Busy), .Err_zero(Err_zero)
  );
  always #5 Clk = ~Clk;
  beat_t exp_q[$];
  int cmp = 0, bad = 0, bp_pct = 0, rx_total = 0, frame_cnt = 0;
  logic prev_stall = 0, last_prev = 0, pu, pl;
  logic [W-1:0] pd;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask
  always @(posedge Clk) begin
    #1 m.tready = $urandom_range(99) >= bp_pct;
  end
  always @(negedge Clk) begin
    if (Rst) begin
      prev_stall = 0;
      last_prev = 0;
    end else begin
      beat_t e;
      if (last_prev) begin
        chk("busy_after_last", Busy, 0);
        chk("cmd_ready_after_last", Cmd_ready, 1);
      end
      last_prev = 0;
      if (prev_stall) chk("stall_hold", {m.tvalid, m.tuser, m.tlast, m.tdata}, {1'b1, pu, pl, pd});
      if (!Busy) frame_cnt = 0;
      else if (frame_cnt < 3 * B) chk("blk_ready_in_header", Blk_ready, 0);
      if (m.tvalid) chk("tkeep", m.tkeep, KEEP);
      else chk("tlast_idle", m.tlast, 0);
      if (m.tvalid && m.tready) begin
        rx_total++;
        frame_cnt++;
        if (exp_q.size() == 0) begin
          cmp++;
          bad++;
          $display("FAIL unexpected_beat: got %h required none", m.tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m.tdata, e.d);
          chk("beat_tuser", m.tuser, e.u);
          chk("beat_tlast", m.tlast, e.l);
        end
        last_prev = m.tlast;
      end
      prev_stall = m.tvalid & ~m.tready;
      pd = m.tdata;
      pu = m.tuser;
      pl = m.tlast;
    end
  end
  // Reference: a message is the word list {key lo, key hi, iv, blocks...}, each cut into W-bit beats
  task automatic model_push(input logic [255:0] key, input logic [127:0] iv, input logic enc, input logic [127:0] blks[$]);
    logic [127:0] w[$];
    logic [127:0] t;
    beat_t e;
    w = {key[127:0], key[255:128], iv};
    foreach (blks[i]) w.push_back(blks[i]);
    for (int i = 0; i < w.size(); i++) begin
      t = w[i];
      for (int b = 0; b < B; b++) begin
        e.d = t[b*W +: W];
        e.u = enc;
        e.l = (i == w.size() - 1) && (b == B - 1);
        exp_q.push_back(e);
      end
    end
  endtask
  task automatic send_cmd(input logic [255:0] key, input logic [127:0] iv, input logic enc, input logic [LW-1:0] n);
    logic got = 0;
    Cmd_key = key;
    Cmd_iv = iv;
    Cmd_enc = enc;
    Cmd_nblocks = n;
    Cmd_valid = 1;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge Clk);
      got = Cmd_ready;
      @(posedge Clk);
      #1;
    end
    Cmd_valid = 0;
    if (!got) chk("cmd_accept_timeout", 0, 1);
  endtask
  task automatic send_blk(input logic [127:0] d);
    logic got = 0;
    Blk_data = d;
    Blk_valid = 1;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge Clk);
      got = Blk_ready;
      @(posedge Clk);
      #1;
    end
    Blk_valid = 0;
    if (!got) chk("blk_accept_timeout", 0, 1);
  endtask
  task automatic wait_idle();
    logic idle = 0;
    for (int i = 0; i < 2000 && !idle; i++) begin
      @(negedge Clk);
      idle = !Busy;
    end
    @(posedge Clk);
    #1;
    if (!idle) chk("idle_timeout", 0, 1);
  endtask
  task automatic run_frame(input logic [255:0] key, input logic [127:0] iv, input logic enc, input logic [127:0] blks[$], input int bp);
    int r0;
    bp_pct = bp;
    r0 = rx_total;
    model_push(key, iv, enc, blks);
    send_cmd(key, iv, enc, LW'(blks.size()));
    @(negedge Clk);
    chk("first_beat_latency", m.tvalid, 1);
    @(posedge Clk);
    #1;
    foreach (blks[i]) send_blk(blks[i]);
    wait_idle();
    chk("beat_count", rx_total - r0, B * (3 + blks.size()));
    chk("queue_drained", exp_q.size(), 0);
  endtask
  task automatic run_rand(input logic enc, input int n, input int bp);
    logic [127:0] blks[$];
    for (int i = 0; i < n; i++) blks.push_back({$urandom, $urandom, $urandom, $urandom});
    run_frame({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, enc, blks, bp);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end
  initial begin
    logic [255:0] key;
    logic [127:0] blks[$];
    int cyc, errc;
    logic tv, bz, hs;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_cmd_ready", Cmd_ready, 1);
    chk("rst_blk_ready", Blk_ready, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_err_zero", Err_zero, 0);
    chk("rst_tvalid", m.tvalid, 0);
    chk("rst_tlast", m.tlast, 0);
    chk("rst_tdata", m.tdata, 0);
    chk("rst_tkeep", m.tkeep, 0);
    chk("rst_tuser", m.tuser, 0);
    @(posedge Clk);
    #1 Rst = 0;
    for (int i = 0; i < 32; i++) key[i*8 +: 8] = 8'(i);
    blks = {128'h00112233445566778899aabbccddeeff};
    run_frame(key, '0, 1, blks, 0);
    run_rand(0, 3, 50);
    send_cmd(key, '0, 1, '0);
    errc = 0;
    tv = 0;
    bz = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      errc += int'(Err_zero);
      tv |= m.tvalid;
      bz |= Busy;
    end
    @(posedge Clk);
    #1;
    chk("err_zero_width", errc, 1);
    chk("err_zero_no_tvalid", tv, 0);
    chk("err_zero_not_busy", bz, 0);
    bp_pct = 0;
    blks = {{$urandom, $urandom, $urandom, $urandom}};
    model_push(key, ~128'h0, 0, blks);
    Blk_data = blks[0];
    Blk_valid = 1;
    send_cmd(key, ~128'h0, 0, 1);
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (!Busy) break;
      cyc++;
      hs = Blk_valid & Blk_ready;
      @(posedge Clk);
      #1;
      if (hs) Blk_valid = 0;
    end
    @(posedge Clk);
    #1;
    Blk_valid = 0;
    chk("early_blk_busy_cycles", cyc, 4 * B + 1);
    chk("early_blk_drained", exp_q.size(), 0);
    blks = {{$urandom, $urandom, $urandom, $urandom}};
    model_push(key, '1, 1, blks);
    send_cmd(key, '1, 1, 1);
    repeat (3 * B) @(negedge Clk);
    chk("iv_beat_valid_before_rst", m.tvalid, 1);
    #1 Rst = 1;
    @(posedge Clk);
    #1 Rst = 0;
    exp_q.delete();
    @(negedge Clk);
    chk("abort_tvalid", m.tvalid, 0);
    chk("abort_cmd_ready", Cmd_ready, 1);
    chk("abort_busy", Busy, 0);
    @(posedge Clk);
    #1;
    run_rand(1, 1, 0);
    for (int k = 0; k < 8; k++) run_rand(1'($urandom_range(1)), $urandom_range(1, 4), (k % 3) * 30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
